// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   F3_*         : RV32I load/store funct3 encodings
//   lsu_state_t  : access sequencer states
//   f3_is_legal  : funct3 values the unit accepts
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   function automatic logic f3_is_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   Request side (current instruction):
//     req_funct3, req_off, req_wdata  in  : access size/sign, addr[1:0], store data
//     req_legal                       out : funct3 legal and address aligned for its size
//     req_be, req_lane_wdata          out : byte enables and lane-replicated store data
//   Load side (latched access):
//     ld_funct3, ld_off, ld_word      in  : latched funct3/addr[1:0], bus read word
//     ld_data                         out : selected lane, sign/zero extended
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_off,
   input  logic [31:0] req_wdata,
   output logic        req_legal,
   output logic [3:0]  req_be,
   output logic [31:0] req_lane_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      req_legal      = 1'b0;
      req_be         = 4'b0000;
      req_lane_wdata = 32'h0;
      case (req_funct3)
         F3_B, F3_BU: begin
            req_legal      = 1'b1;
            req_be         = 4'b0001 << req_off;
            req_lane_wdata = {4{req_wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            req_legal      = ~req_off[0];
            req_be         = req_off[1] ? 4'b1100 : 4'b0011;
            req_lane_wdata = {2{req_wdata[15:0]}};
         end
         F3_W: begin
            req_legal      = (req_off == 2'b00);
            req_be         = 4'b1111;
            req_lane_wdata = req_wdata;
         end
         default: begin
            req_legal = 1'b0;
         end
      endcase
   end

   always_comb begin
      ld_byte = ld_word[7:0];
      case (ld_off)
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

      ld_data = ld_word;
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data = {24'h0, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {16'h0, ld_half};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns RV32I loads/stores into aligned word
// bus requests with byte enables, extends load data and stalls the pipeline
// until the bus acknowledges or the wait counter expires.
//
//   state | meaning
//   IDLE  | waiting for a live load/store; illegal ones pulse fault
//   BUSY  | mem_req high, waiting for mem_ack or timeout
//   DONE  | one-cycle completion, pipeline advances, nothing accepted
//
// Ports:
//   clk, reset                        single clock, synchronous active-high reset
//   valid_i, rd_en, wr_en, funct3     instruction qualifiers (wr_en wins over rd_en)
//   addr, wdata                       byte address and store data
//   rdata                             extended load result (registered)
//   stall                             freeze upstream pipeline registers
//   done, fault, bus_err              one-cycle status pulses
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata                 registered word bus request
//   mem_ack, mem_rdata                bus completion and read word
//
// TIMEOUT is the number of BUSY cycles without mem_ack before the access is
// aborted; an ack in the last allowed cycle still completes normally.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        fault,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_t        state;
   lsu_state_t        state_next;
   logic [CNT_W-1:0]  wait_cnt;
   logic [2:0]        ld_funct3;
   logic [1:0]        ld_off;

   logic              op;
   logic              req_legal;
   logic [3:0]        req_be;
   logic [31:0]       req_lane_wdata;
   logic [31:0]       ld_data;
   logic              accept;
   logic              reject;
   logic              ack_hit;
   logic              timeout_hit;

   lsu_align u_align (
      .req_funct3     (funct3),
      .req_off        (addr[1:0]),
      .req_wdata      (wdata),
      .req_legal      (req_legal),
      .req_be         (req_be),
      .req_lane_wdata (req_lane_wdata),
      .ld_funct3      (ld_funct3),
      .ld_off         (ld_off),
      .ld_word        (mem_rdata),
      .ld_data        (ld_data)
   );

   assign op          = valid_i & (rd_en | wr_en);
   assign accept      = (state == IDLE) & op & req_legal & f3_is_legal(funct3);
   assign reject      = (state == IDLE) & op & ~(req_legal & f3_is_legal(funct3));
   assign ack_hit     = (state == BUSY) & mem_ack;
   // ack has priority over an expiry in the same cycle
   assign timeout_hit = (state == BUSY) & ~mem_ack & (wait_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      stall      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               stall      = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (ack_hit || timeout_hit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata     <= 32'h0;
         fault     <= 1'b0;
         bus_err   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'h0;
         wait_cnt  <= '0;
         ld_funct3 <= 3'b000;
         ld_off    <= 2'b00;
      end else begin
         fault   <= reject;
         bus_err <= timeout_hit;

         if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= wr_en;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= req_be;
            mem_wdata <= req_lane_wdata;
            ld_funct3 <= funct3;
            ld_off    <= addr[1:0];
            wait_cnt  <= '0;
         end

         if (ack_hit) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
               rdata <= ld_data;
            end
         end else if (timeout_hit) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
               rdata <= 32'h0;
            end
         end else if (state == BUSY) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i, rd_en, wr_en;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        stall, done, fault, bus_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_i   (valid_i),
      .rd_en     (rd_en),
      .wr_en     (wr_en),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .done      (done),
      .fault     (fault),
      .bus_err   (bus_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } req_t;

   // kind: 0 = normal completion, 1 = timeout abort, 2 = fault
   typedef struct {
      int          kind;
      logic [31:0] rdata;
   } resp_t;

   req_t        req_q[$];
   resp_t       resp_q[$];
   logic [7:0]  ref_mem[int];
   logic [31:0] bus_mem[int];
   logic [31:0] model_rdata;
   int          ack_lat;
   logic        manual_ack;
   int          checks = 0;
   int          failures = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic set_word(input int a, input logic [31:0] v);
      bus_mem[a] = v;
      for (int b = 0; b < 4; b++) ref_mem[a + b] = v[8*b +: 8];
   endtask

   // Reference model: byte-addressed memory and RV32I access semantics.
   // lat = extra BUSY cycles before ack (0 = ack in first request cycle), <0 = never.
   task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int lat);
      int          sz, n, exp_stall, off;
      bit          ok, s;
      req_t        rq;
      resp_t       rs;
      logic [31:0] v;
      sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off = int'(a[1:0]);
      ok  = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101)
            && ((off % sz) == 0);
      if (!ok) begin
         rs.kind  = 2;
         rs.rdata = model_rdata;
         resp_q.push_back(rs);
         exp_stall = 0;
      end else begin
         rq.addr  = a & ~32'h3;
         rq.we    = st;
         rq.be    = 4'b0000;
         rq.wdata = 32'h0;
         for (int i = 0; i < sz; i++) rq.be[off + i] = 1'b1;
         if (st) for (int i = 0; i < 4; i++) rq.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
         req_q.push_back(rq);
         if (lat < 0) begin
            rs.kind = 1;
            if (!st) model_rdata = 32'h0;
            exp_stall = 1 + TIMEOUT;
         end else begin
            rs.kind   = 0;
            exp_stall = lat + 2;
            if (st) begin
               for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end else begin
               v = 32'h0;
               for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
               if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 32'h1);
               model_rdata = v;
            end
         end
         rs.rdata = model_rdata;
         resp_q.push_back(rs);
      end

      ack_lat = lat;
      valid_i = 1'b1;
      wr_en   = st;
      rd_en   = st ? 1'($urandom_range(0, 1)) : 1'b1;
      funct3  = f3;
      addr    = a;
      wdata   = wd;
      n = 0;
      do begin
         @(negedge clk);
         s = stall;
         @(posedge clk);
         #1;
         if (s) n++;
      end while (s && n <= TIMEOUT + 20);
      chk("stall_cycles", n, exp_stall);
      valid_i = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      funct3  = 3'($urandom);
      addr    = $urandom;
      wdata   = $urandom;
   endtask

   // Bus responder: backing word memory, programmable ack latency.
   initial begin
      bit          in_req;
      int          cnt;
      logic [31:0] w;
      in_req    = 1'b0;
      cnt       = -1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         mem_ack   = manual_ack;
         mem_rdata = $urandom;
         if (!mem_req) begin
            in_req = 1'b0;
         end else begin
            if (!in_req) begin
               in_req = 1'b1;
               cnt    = ack_lat;
            end
            if (cnt == 0) begin
               mem_ack = 1'b1;
               w = bus_mem[int'(mem_addr)];
               if (mem_we) begin
                  for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                  bus_mem[int'(mem_addr)] = w;
               end else begin
                  mem_rdata = w;
               end
               cnt = -1;
            end else if (cnt > 0) begin
               cnt--;
            end
         end
      end
   end

   // Monitor: compares bus requests and completions against the scoreboard.
   initial begin
      bit    prev_req;
      req_t  rq;
      resp_t rs;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_req = 1'b0;
         end else begin
            if (mem_req && !prev_req) begin
               if (req_q.size() == 0) begin
                  chk("spurious_mem_req", 32'(mem_req), 32'h0);
               end else begin
                  rq = req_q.pop_front();
                  chk("mem_addr", mem_addr, rq.addr);
                  chk("mem_be", 32'(mem_be), 32'(rq.be));
                  chk("mem_we", 32'(mem_we), 32'(rq.we));
                  if (rq.we) chk("mem_wdata", mem_wdata, rq.wdata);
               end
            end
            prev_req = mem_req;
            if (done || fault) begin
               if (resp_q.size() == 0) begin
                  chk("spurious_done_fault", 32'({done, fault}), 32'h0);
               end else begin
                  rs = resp_q.pop_front();
                  chk("done", 32'(done), 32'(rs.kind != 2));
                  chk("fault", 32'(fault), 32'(rs.kind == 2));
                  chk("bus_err", 32'(bus_err), 32'(rs.kind == 1));
                  chk("rdata", rdata, rs.rdata);
                  if (done) chk("stall_in_done", 32'(stall), 32'h0);
               end
            end else if (bus_err) begin
               chk("bus_err_without_done", 32'(bus_err), 32'h0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      bit          st;
      logic [2:0]  f3;
      reset       = 1'b1;
      valid_i     = 1'b0;
      rd_en       = 1'b0;
      wr_en       = 1'b0;
      funct3      = 3'b000;
      addr        = 32'h0;
      wdata       = 32'h0;
      manual_ack  = 1'b0;
      ack_lat     = 0;
      model_rdata = 32'h0;
      for (int w = 0; w < 128; w++) begin
         v = $urandom;
         set_word(32'h100 + 4*w, v);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_be", 32'(mem_be), 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_pulses", 32'({done, fault, bus_err}), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // SW, zero-wait bus
      do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0);
      chk("sw_be", 32'(mem_be), 32'hF);

      // LB / LBU sign and zero extension
      set_word(32'h200, 32'h80FF_0000);
      do_op(1'b0, 3'b000, 32'h203, 32'h0, 2);
      chk("lb_rdata", rdata, 32'hFFFFFF80);
      do_op(1'b0, 3'b100, 32'h203, 32'h0, 2);
      chk("lbu_rdata", rdata, 32'h00000080);

      // SH upper half, then misaligned LH
      do_op(1'b1, 3'b001, 32'h102, 32'h00001234, 1);
      chk("sh_be", 32'(mem_be), 32'hC);
      chk("sh_wdata", mem_wdata, 32'h12341234);
      do_op(1'b0, 3'b001, 32'h101, 32'h0, 0);

      // Timeout abort on a load
      do_op(1'b0, 3'b010, 32'h104, 32'h0, -1);
      chk("timeout_rdata", rdata, 32'h0);

      // Reset while BUSY, late ack afterwards
      do_op(1'b0, 3'b010, 32'h200, 32'h0, 1);
      ack_lat = -1;
      req_q.push_back('{addr: 32'h110, be: 4'hF, we: 1'b0, wdata: 32'h0});
      valid_i = 1'b1;
      rd_en   = 1'b1;
      wr_en   = 1'b0;
      funct3  = 3'b010;
      addr    = 32'h110;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      rd_en   = 1'b0;
      @(posedge clk);
      #1;
      chk("busy_mem_req", 32'(mem_req), 32'h1);
      chk("busy_stall", 32'(stall), 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      manual_ack  = 1'b1;
      model_rdata = 32'h0;
      chk("post_rst_mem_req", 32'(mem_req), 32'h0);
      chk("post_rst_rdata", rdata, 32'h0);
      chk("post_rst_stall", 32'(stall), 32'h0);
      @(posedge clk);
      #1;
      manual_ack = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("late_ack_no_done", 32'(done), 32'h0);
         chk("late_ack_no_req", 32'(mem_req), 32'h0);
      end
      @(posedge clk);
      #1;

      // Back-to-back LW with immediate ack
      do_op(1'b0, 3'b010, 32'h108, 32'h0, 0);
      do_op(1'b0, 3'b010, 32'h10C, 32'h0, 0);

      // Randomized traffic
      repeat (200) begin
         repeat ($urandom_range(0, 2)) begin
            valid_i = 1'($urandom);
            rd_en   = 1'b0;
            wr_en   = 1'b0;
            funct3  = 3'($urandom);
            addr    = $urandom;
            @(posedge clk);
            #1;
         end
         st = ($urandom_range(0, 2) == 0);
         if (st) begin
            case ($urandom_range(0, 7))
               0, 1:    f3 = 3'b000;
               2, 3:    f3 = 3'b001;
               4, 5:    f3 = 3'b010;
               6:       f3 = 3'b011;
               default: f3 = 3'b110;
            endcase
         end else begin
            f3 = 3'($urandom);
         end
         do_op(st, f3, 32'h100 + 32'($urandom_range(0, 511)), $urandom, $urandom_range(0, 4));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("req_q_drained", 32'(req_q.size()), 32'h0);
      chk("resp_q_drained", 32'(resp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
